// File: rtl/b06_pkg.sv
// rtl/b06_pkg.sv - shared codes and types for the b06 interrupt requester
package b06_pkg;

  localparam logic [1:0] CC_RESET  = 2'b00;
  localparam logic [1:0] CC_ENIN   = 2'b01;
  localparam logic [1:0] CC_INTR   = 2'b10;
  localparam logic [1:0] CC_ACKIN  = 2'b11;

  localparam logic [1:0] US_ACK    = 2'b00;
  localparam logic [1:0] US_NORM   = 2'b01;
  localparam logic [1:0] US_INTR_W = 2'b11;

  typedef enum logic {
    ENIN = 1'b0,
    INTR = 1'b1
  } req_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    REL  = 2'd3
  } state_e;

  // handler code that grants a request of the given type
  function automatic logic [1:0] req_code(input req_type_e t);
    return (t == INTR) ? CC_INTR : CC_ENIN;
  endfunction

  // handler status that closes a transaction of the given type
  function automatic logic [1:0] done_code(input req_type_e t);
    return (t == INTR) ? US_INTR_W : US_NORM;
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// rtl/sat_updown_cnt.sv - saturating up/down pending-request counter
module sat_updown_cnt #(
  parameter int W = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  assign full  = (count == {W{1'b1}});
  assign empty = (count == '0);

  // simultaneous inc and dec cancel; inc at full and dec at empty are ignored
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + ONE;
    end else if (dec && !inc && !empty) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/b06_irq_requester.sv
// rtl/b06_irq_requester.sv - peripheral-side requester closing the loop with the b06 handler
module b06_irq_requester
  import b06_pkg::*;
#(
  parameter int PEND_W    = 3,
  parameter int HOLD_CYC  = 2,
  parameter int TIMEOUT   = 15,
  parameter int CNT_W     = 4,
  parameter int CNT_LIMIT = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_enin,
  input  logic       req_intr,
  input  logic [1:0] cc_mux,
  input  logic [1:0] uscite,
  input  logic       enable_count,
  input  logic       ackout,
  output logic       eql,
  output logic       cont_eql,
  output logic       done_enin,
  output logic       done_intr,
  output logic       timeout_err,
  output logic       overflow,
  output logic       busy,
  output logic [7:0] ack_total
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MATCH = CNT_W'(CNT_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_e            state;
  state_e            state_nxt;
  req_type_e         cur_type;
  logic [WAIT_W-1:0] wait_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CNT_W-1:0]  cnt;

  logic dispatch_enin;
  logic dispatch_intr;
  logic timed_out;
  logic finish;
  logic enin_full;
  logic enin_empty;
  logic intr_full;
  logic intr_empty;

  sat_updown_cnt #(.W(PEND_W)) u_pend_enin (
    .clock (clock),
    .reset (reset),
    .inc   (req_enin),
    .dec   (dispatch_enin),
    .full  (enin_full),
    .empty (enin_empty)
  );

  sat_updown_cnt #(.W(PEND_W)) u_pend_intr (
    .clock (clock),
    .reset (reset),
    .inc   (req_intr),
    .dec   (dispatch_intr),
    .full  (intr_full),
    .empty (intr_empty)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and transaction events; interrupts win dispatch, grant wins over timeout
  always_comb begin
    state_nxt     = state;
    dispatch_enin = 1'b0;
    dispatch_intr = 1'b0;
    timed_out     = 1'b0;
    finish        = 1'b0;
    case (state)
      IDLE: begin
        if (!intr_empty) begin
          state_nxt     = REQ;
          dispatch_intr = 1'b1;
        end else if (!enin_empty) begin
          state_nxt     = REQ;
          dispatch_enin = 1'b1;
        end
      end
      REQ: begin
        if (cc_mux == CC_ACKIN) begin
          state_nxt = HOLD;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = IDLE;
          timed_out = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = REL;
        end
      end
      REL: begin
        if (cc_mux != CC_ACKIN && uscite == done_code(cur_type)) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // request level follows the handler code while waiting and is forced high while holding
  always_comb begin
    busy = (state != IDLE);
    eql  = (state == HOLD) || ((state == REQ) && (cc_mux == req_code(cur_type)));
  end

  // transaction datapath: latched type, phase timers, completion pulses, sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_type    <= ENIN;
      wait_cnt    <= '0;
      hold_cnt    <= '0;
      done_enin   <= 1'b0;
      done_intr   <= 1'b0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (dispatch_intr) begin
        cur_type <= INTR;
      end else if (dispatch_enin) begin
        cur_type <= ENIN;
      end
      wait_cnt    <= (state == REQ)  ? wait_cnt + WAIT_ONE : '0;
      hold_cnt    <= (state == HOLD) ? hold_cnt + HOLD_ONE : '0;
      done_enin   <= finish && (cur_type == ENIN);
      done_intr   <= finish && (cur_type == INTR);
      timeout_err <= timed_out;
      overflow    <= overflow
                   | (req_enin && enin_full && !dispatch_enin)
                   | (req_intr && intr_full && !dispatch_intr);
    end
  end

  // enable_count cycle counter; the match cycle restarts it and fires a one-cycle cont_eql
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      cont_eql <= 1'b0;
    end else if (enable_count && cnt == CNT_MATCH) begin
      cnt      <= '0;
      cont_eql <= 1'b1;
    end else begin
      cont_eql <= 1'b0;
      if (enable_count) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // saturating tally of acknowledge cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      ack_total <= 8'd0;
    end else if (ackout && ack_total != 8'hFF) begin
      ack_total <= ack_total + 8'd1;
    end
  end

endmodule

// File: tb/tb_b06_irq_requester.sv
// tb/tb_b06_irq_requester.sv - self-checking bench for b06_irq_requester
module tb_b06_irq_requester;

  localparam int CNT_LIMIT = 9;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_enin;
  logic       req_intr;
  logic [1:0] cc_mux;
  logic [1:0] uscite;
  logic       enable_count;
  logic       ackout;
  logic       eql;
  logic       cont_eql;
  logic       done_enin;
  logic       done_intr;
  logic       timeout_err;
  logic       overflow;
  logic       busy;
  logic [7:0] ack_total;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference state: enabled cycles since reset, acks since reset, queue depths
  int m_en    = 0;
  bit m_cont  = 1'b0;
  int m_ack   = 0;
  int pend_i  = 0;
  int pend_e  = 0;
  bit rand_en = 1'b0;

  b06_irq_requester #(
    .PEND_W    (3),
    .HOLD_CYC  (2),
    .TIMEOUT   (15),
    .CNT_W     (4),
    .CNT_LIMIT (CNT_LIMIT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_enin     (req_enin),
    .req_intr     (req_intr),
    .cc_mux       (cc_mux),
    .uscite       (uscite),
    .enable_count (enable_count),
    .ackout       (ackout),
    .eql          (eql),
    .cont_eql     (cont_eql),
    .done_enin    (done_enin),
    .done_intr    (done_intr),
    .timeout_err  (timeout_err),
    .overflow     (overflow),
    .busy         (busy),
    .ack_total    (ack_total)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // advance one clock, updating the count/ack reference from the inputs the edge samples
  task automatic tick();
    if (rand_en) enable_count = 1'($urandom_range(0, 1));
    if (reset) begin
      m_en   = 0;
      m_cont = 1'b0;
      m_ack  = 0;
    end else begin
      if (enable_count) begin
        m_en++;
        m_cont = ((m_en % (CNT_LIMIT + 1)) == 0);
      end else begin
        m_cont = 1'b0;
      end
      if (ackout && m_ack < 255) m_ack++;
    end
    @(negedge clock);
    cyc++;
    chk("cont_eql", 32'(cont_eql), 32'(m_cont));
    chk("ack_total", 32'(ack_total), m_ack);
  endtask

  // play the handler through one full transaction of the type the queues say is next
  task automatic serve();
    int         typ;
    int         waited;
    logic [1:0] code;
    logic [1:0] wrong;
    logic [1:0] ucode;
    typ    = (pend_i > 0) ? 1 : 0;
    code   = typ ? 2'b10 : 2'b01;
    wrong  = typ ? 2'b01 : 2'b10;
    ucode  = typ ? 2'b11 : 2'b01;
    waited = 0;
    while (!busy && waited < 4) begin
      tick();
      waited++;
    end
    chk("dispatch_busy", 32'(busy), 1);
    if (typ == 1) pend_i--; else pend_e--;
    repeat ($urandom_range(0, 4)) begin
      tick();
      chk("req_wait_eql", 32'(eql), 0);
    end
    cc_mux = wrong;
    #1;
    chk("eql_wrong_type", 32'(eql), 0);
    cc_mux = code;
    #1;
    chk("eql_req", 32'(eql), 1);
    cc_mux = 2'b11;
    ackout = 1'b1;
    tick();
    ackout = 1'b0;
    chk("eql_hold0", 32'(eql), 1);
    tick();
    chk("eql_hold1", 32'(eql), 1);
    tick();
    chk("eql_rel", 32'(eql), 0);
    chk("busy_rel", 32'(busy), 1);
    cc_mux = 2'b00;
    uscite = 2'b00;
    repeat ($urandom_range(0, 3)) begin
      tick();
      chk("rel_no_done", 32'({done_enin, done_intr}), 0);
    end
    uscite = ucode;
    tick();
    chk("done_enin", 32'(done_enin), 32'(typ == 0));
    chk("done_intr", 32'(done_intr), 32'(typ == 1));
    chk("no_timeout", 32'(timeout_err), 0);
    uscite = 2'b01;
  endtask

  initial begin
    int ni;
    int ne;
    reset        = 1'b1;
    req_enin     = 1'b0;
    req_intr     = 1'b0;
    cc_mux       = 2'b00;
    uscite       = 2'b00;
    enable_count = 1'b0;
    ackout       = 1'b0;
    repeat (2) tick();

    // reset state
    chk("rst_eql", 32'(eql), 0);
    chk("rst_done", 32'({done_enin, done_intr, timeout_err}), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pend_enin", 32'(dut.u_pend_enin.count), 0);
    chk("rst_pend_intr", 32'(dut.u_pend_intr.count), 0);
    reset  = 1'b0;
    uscite = 2'b01;
    tick();
    tick();

    // single enable-in transaction
    req_enin = 1'b1;
    pend_e++;
    tick();
    req_enin = 1'b0;
    chk("t1_idle_after_req", 32'(busy), 0);
    serve();
    tick();
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_pend_enin", 32'(dut.u_pend_enin.count), 0);

    // simultaneous requests: interrupt first
    req_enin = 1'b1;
    req_intr = 1'b1;
    pend_e++;
    pend_i++;
    tick();
    req_enin = 1'b0;
    req_intr = 1'b0;
    serve();
    serve();
    tick();
    chk("t2_busy_after", 32'(busy), 0);

    // overflow while busy, then timeout of the stuck interrupt request
    req_intr = 1'b1;
    pend_i++;
    tick();
    req_intr = 1'b0;
    tick();
    chk("t4_req_entry", 32'(busy), 1);
    for (int k = 1; k <= 15; k++) begin
      req_enin = (k <= 8);
      tick();
      chk("t4_timeout_err", 32'(timeout_err), 32'(k == 15));
      chk("t4_eql", 32'(eql), 0);
      if (k == 8) begin
        chk("t3_pend_enin", 32'(dut.u_pend_enin.count), 7);
        chk("t3_overflow", 32'(overflow), 1);
      end
    end
    req_enin = 1'b0;
    pend_i--;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_pend_intr", 32'(dut.u_pend_intr.count), 0);
    chk("t4_overflow_sticky", 32'(overflow), 1);
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    pend_e = 0;
    chk("t3_overflow_cleared", 32'(overflow), 0);
    chk("t3_pend_cleared", 32'(dut.u_pend_enin.count), 0);
    chk("t3_busy_cleared", 32'(busy), 0);

    // cont_eql on every tenth enabled cycle
    enable_count = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("t5_cont_eql", 32'(cont_eql), 32'(k == 10 || k == 20));
    end
    enable_count = 1'b0;
    tick();

    // ack_total saturation
    ackout = 1'b1;
    repeat (260) tick();
    ackout = 1'b0;
    chk("ack_saturated", 32'(ack_total), 255);

    // reset while holding
    req_enin = 1'b1;
    pend_e++;
    tick();
    req_enin = 1'b0;
    tick();
    chk("t6_req", 32'(busy), 1);
    cc_mux = 2'b01;
    #1;
    chk("t6_eql_req", 32'(eql), 1);
    cc_mux = 2'b11;
    tick();
    chk("t6_eql_hold", 32'(eql), 1);
    reset  = 1'b1;
    cc_mux = 2'b00;
    tick();
    pend_e = 0;
    chk("t6_eql", 32'(eql), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'({done_enin, done_intr, timeout_err}), 0);
    chk("t6_pend_enin", 32'(dut.u_pend_enin.count), 0);
    reset = 1'b0;
    tick();
    chk("t6_no_done_after", 32'({done_enin, done_intr}), 0);
    chk("t6_idle_after", 32'(busy), 0);

    // randomized request bursts drained by the handler
    rand_en = 1'b1;
    for (int it = 0; it < 25; it++) begin
      ni = $urandom_range(0, 2);
      ne = $urandom_range(0, 2);
      for (int j = 0; j < ((ni > ne) ? ni : ne); j++) begin
        req_intr = (j < ni);
        req_enin = (j < ne);
        if (j < ni) pend_i++;
        if (j < ne) pend_e++;
        tick();
      end
      req_intr = 1'b0;
      req_enin = 1'b0;
      while (pend_i + pend_e > 0) serve();
      tick();
      chk("rnd_idle", 32'(busy), 0);
      chk("rnd_overflow", 32'(overflow), 0);
    end
    rand_en      = 1'b0;
    enable_count = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
